// File: rtl/sub_arbiter.sv
// Arbiter sharing one combinational 32-bit S-box unit between the cipher state datapath
// (serialised NWORDS words, MS word first) and key expansion (single forward SubWord).

module sub_arbiter #(
    parameter int unsigned NWORDS   = 4,
    parameter bit          KEY_PRIO = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   st_valid_i,
    output logic                   st_ready_o,
    input  logic                   st_dir_i,
    input  logic [32*NWORDS-1:0]   st_data_i,
    output logic                   st_done_o,
    output logic [32*NWORDS-1:0]   st_result_o,
    input  logic                   ky_valid_i,
    output logic                   ky_ready_o,
    input  logic [31:0]            ky_word_i,
    output logic                   ky_done_o,
    output logic [31:0]            ky_result_o,
    output logic                   sw_dir_o,
    output logic [31:0]            sw_word_o,
    input  logic [31:0]            sw_subbed_i,
    output logic                   busy_o
);

    localparam int unsigned    CntW    = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int unsigned    DataW   = 32 * NWORDS;
    localparam logic [CntW-1:0] CntLast = CntW'(NWORDS - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStRun,
        StKyRun
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               last_key_q, last_key_d;
    logic [DataW-1:0]   st_data_q, st_data_d;
    logic               st_dir_q, st_dir_d;
    logic [DataW-1:0]   st_result_q, st_result_d;
    logic [31:0]        ky_word_q, ky_word_d;
    logic [31:0]        ky_result_q, ky_result_d;
    logic               st_done_q, st_done_d;
    logic               ky_done_q, ky_done_d;

    logic               grant_key;
    logic               idle;
    logic [31:0]        sel_word;

    assign idle = (state_q == StIdle);

    always_comb begin
        grant_key = ky_valid_i;
        if (st_valid_i && ky_valid_i) begin
            grant_key = KEY_PRIO ? 1'b1 : !last_key_q;
        end
    end

    // Gated by reset so nothing is offered while the block is held in reset.
    assign st_ready_o = reset_ni && idle && st_valid_i && !grant_key;
    assign ky_ready_o = reset_ni && idle && ky_valid_i && grant_key;

    always_comb begin
        sel_word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (cnt_q == CntW'(i)) begin
                sel_word = st_data_q[32*(NWORDS-1-i) +: 32];
            end
        end
    end

    always_comb begin
        sw_word_o = '0;
        sw_dir_o  = 1'b0;
        unique case (state_q)
            StStRun: begin
                sw_word_o = sel_word;
                sw_dir_o  = st_dir_q;
            end
            StKyRun: begin
                sw_word_o = ky_word_q;
            end
            default: begin
                sw_word_o = '0;
                sw_dir_o  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_key_d  = last_key_q;
        st_data_d   = st_data_q;
        st_dir_d    = st_dir_q;
        st_result_d = st_result_q;
        ky_word_d   = ky_word_q;
        ky_result_d = ky_result_q;
        st_done_d   = 1'b0;
        ky_done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (st_ready_o) begin
                    st_data_d  = st_data_i;
                    st_dir_d   = st_dir_i;
                    cnt_d      = '0;
                    last_key_d = 1'b0;
                    state_d    = StStRun;
                end else if (ky_ready_o) begin
                    ky_word_d  = ky_word_i;
                    last_key_d = 1'b1;
                    state_d    = StKyRun;
                end
            end
            StStRun: begin
                for (int unsigned i = 0; i < NWORDS; i++) begin
                    if (cnt_q == CntW'(i)) begin
                        st_result_d[32*(NWORDS-1-i) +: 32] = sw_subbed_i;
                    end
                end
                if (cnt_q == CntLast) begin
                    cnt_d     = '0;
                    st_done_d = 1'b1;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StKyRun: begin
                ky_result_d = sw_subbed_i;
                ky_done_d   = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_key_q  <= 1'b1;
            st_data_q   <= '0;
            st_dir_q    <= 1'b0;
            st_result_q <= '0;
            ky_word_q   <= '0;
            ky_result_q <= '0;
            st_done_q   <= 1'b0;
            ky_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_key_q  <= last_key_d;
            st_data_q   <= st_data_d;
            st_dir_q    <= st_dir_d;
            st_result_q <= st_result_d;
            ky_word_q   <= ky_word_d;
            ky_result_q <= ky_result_d;
            st_done_q   <= st_done_d;
            ky_done_q   <= ky_done_d;
        end
    end

    assign st_done_o   = st_done_q;
    assign st_result_o = st_result_q;
    assign ky_done_o   = ky_done_q;
    assign ky_result_o = ky_result_q;
    assign busy_o      = !idle;

endmodule

// File: tb/tb_sub_arbiter.sv
// Bench for sub_arbiter: instance k has KEY_PRIO = k; a reference AES S-box drives sw_subbed,
// and a transaction-level model predicts every output on each falling clock edge.

module tb_sub_arbiter;

    localparam int unsigned NW = 4;
    localparam int unsigned DW = 32 * NW;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n = 1'b0;

    logic          st_valid[2], st_dir[2], ky_valid[2];
    logic [DW-1:0] st_data[2];
    logic [31:0]   ky_word[2];
    logic          st_ready[2], st_done[2], ky_ready[2], ky_done[2], sw_dir[2], busy[2];
    logic [DW-1:0] st_result[2];
    logic [31:0]   ky_result[2], sw_word[2], sw_subbed[2];

    logic [7:0] sbox [256];
    logic [7:0] isbox [256];

    int n_checks = 0;
    int n_err    = 0;

    // Model state, per instance
    int            m_act[2];      // 0 idle, 1 state run, 2 key run
    int            m_pos[2];      // 1-based index of the word on the unit this cycle
    logic [DW-1:0] m_data[2];
    logic          m_dir[2];
    logic [31:0]   m_key[2];
    logic [DW-1:0] m_st_res[2];
    logic [31:0]   m_ky_res[2];
    logic          m_st_done[2], m_ky_done[2], m_last_key[2];
    logic          m_st_acc[2], m_ky_acc[2];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0] inv, s;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox[a]  = s;
            isbox[s] = 8'(a);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w, input logic inv);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = inv ? isbox[w[8*b +: 8]] : sbox[w[8*b +: 8]];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] subst_state(input logic [DW-1:0] d, input logic inv);
        logic [DW-1:0] r;
        for (int i = 0; i < NW; i++) r[32*i +: 32] = subw(d[32*i +: 32], inv);
        return r;
    endfunction

    assign sw_subbed[0] = subw(sw_word[0], sw_dir[0]);
    assign sw_subbed[1] = subw(sw_word[1], sw_dir[1]);

    sub_arbiter #(.NWORDS(NW), .KEY_PRIO(1'b0)) u_dut0 (
        .clk_i(clk), .reset_ni(reset_n),
        .st_valid_i(st_valid[0]), .st_ready_o(st_ready[0]), .st_dir_i(st_dir[0]),
        .st_data_i(st_data[0]), .st_done_o(st_done[0]), .st_result_o(st_result[0]),
        .ky_valid_i(ky_valid[0]), .ky_ready_o(ky_ready[0]), .ky_word_i(ky_word[0]),
        .ky_done_o(ky_done[0]), .ky_result_o(ky_result[0]),
        .sw_dir_o(sw_dir[0]), .sw_word_o(sw_word[0]), .sw_subbed_i(sw_subbed[0]),
        .busy_o(busy[0])
    );

    sub_arbiter #(.NWORDS(NW), .KEY_PRIO(1'b1)) u_dut1 (
        .clk_i(clk), .reset_ni(reset_n),
        .st_valid_i(st_valid[1]), .st_ready_o(st_ready[1]), .st_dir_i(st_dir[1]),
        .st_data_i(st_data[1]), .st_done_o(st_done[1]), .st_result_o(st_result[1]),
        .ky_valid_i(ky_valid[1]), .ky_ready_o(ky_ready[1]), .ky_word_i(ky_word[1]),
        .ky_done_o(ky_done[1]), .ky_result_o(ky_result[1]),
        .sw_dir_o(sw_dir[1]), .sw_word_o(sw_word[1]), .sw_subbed_i(sw_subbed[1]),
        .busy_o(busy[1])
    );

    task automatic chk(input string name, input int k, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] @%0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_act[k] = 0; m_pos[k] = 0; m_data[k] = '0; m_dir[k] = 1'b0; m_key[k] = '0;
        m_st_res[k] = '0; m_ky_res[k] = '0; m_st_done[k] = 1'b0; m_ky_done[k] = 1'b0;
        m_last_key[k] = 1'b1; m_st_acc[k] = 1'b0; m_ky_acc[k] = 1'b0;
    endtask

    task automatic model_cycle(input int k);
        logic gk, e_sr, e_kr, e_dir;
        logic [31:0] e_sw;
        if (!reset_n) model_reset(k);
        e_sr = 1'b0; e_kr = 1'b0;
        if (reset_n && m_act[k] == 0) begin
            // Instance k has KEY_PRIO = k
            if (st_valid[k] && ky_valid[k]) gk = (k == 1) ? 1'b1 : !m_last_key[k];
            else gk = ky_valid[k];
            e_sr = st_valid[k] && !gk;
            e_kr = ky_valid[k] && gk;
        end
        e_sw = '0; e_dir = 1'b0;
        if (m_act[k] == 1) begin
            e_sw  = m_data[k][DW-32*m_pos[k] +: 32];
            e_dir = m_dir[k];
        end else if (m_act[k] == 2) begin
            e_sw = m_key[k];
        end
        chk("st_ready", k, st_ready[k], e_sr);
        chk("ky_ready", k, ky_ready[k], e_kr);
        chk("busy", k, busy[k], m_act[k] != 0);
        chk("sw_word", k, sw_word[k], e_sw);
        chk("sw_dir", k, sw_dir[k], e_dir);
        chk("st_done", k, st_done[k], m_st_done[k]);
        chk("ky_done", k, ky_done[k], m_ky_done[k]);
        chk("ky_result", k, ky_result[k], m_ky_res[k]);
        if (m_act[k] != 1) chk("st_result", k, st_result[k], m_st_res[k]);
        m_st_acc[k] = e_sr; m_ky_acc[k] = e_kr;
        m_st_done[k] = 1'b0; m_ky_done[k] = 1'b0;
        if (reset_n) begin
            case (m_act[k])
                0: if (e_sr) begin
                    m_act[k] = 1; m_pos[k] = 1; m_data[k] = st_data[k];
                    m_dir[k] = st_dir[k]; m_last_key[k] = 1'b0;
                end else if (e_kr) begin
                    m_act[k] = 2; m_key[k] = ky_word[k]; m_last_key[k] = 1'b1;
                end
                1: if (m_pos[k] == NW) begin
                    m_act[k] = 0; m_st_done[k] = 1'b1;
                    m_st_res[k] = subst_state(m_data[k], m_dir[k]);
                end else begin
                    m_pos[k]++;
                end
                default: begin
                    m_act[k] = 0; m_ky_done[k] = 1'b1; m_ky_res[k] = subw(m_key[k], 1'b0);
                end
            endcase
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) model_cycle(k);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 2; k++) begin st_valid[k] = 1'b0; ky_valid[k] = 1'b0; end
        repeat (8) tick();
    endtask

    // Both instances idle; accept at T, words at T+1..T+NW, done at T+NW+1.
    task automatic run_state(input logic [DW-1:0] d, input logic dir, input logic [DW-1:0] res);
        for (int k = 0; k < 2; k++) begin
            st_valid[k] = 1'b1; st_dir[k] = dir; st_data[k] = d; ky_valid[k] = 1'b0;
        end
        #1;
        for (int k = 0; k < 2; k++) chk("t_st_ready", k, st_ready[k], 1);
        tick();
        for (int k = 0; k < 2; k++) st_valid[k] = 1'b0;
        for (int i = 1; i <= NW; i++) begin
            for (int k = 0; k < 2; k++) begin
                chk("t_st_word", k, sw_word[k], d[DW-32*i +: 32]);
                chk("t_st_dir", k, sw_dir[k], dir);
                chk("t_st_done_early", k, st_done[k], 0);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            chk("t_st_done", k, st_done[k], 1);
            chk("t_st_result", k, st_result[k], res);
            chk("t_busy_done", k, busy[k], 0);
        end
        tick();
        for (int k = 0; k < 2; k++) chk("t_st_done_pulse", k, st_done[k], 0);
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [15:0] seq;
        int ngr, nst1, waited;
        logic prev_done, kdone_seen;
        for (int k = 0; k < 2; k++) begin
            st_valid[k] = 1'b0; ky_valid[k] = 1'b0; st_dir[k] = 1'b0;
            st_data[k] = '0; ky_word[k] = '0;
            model_reset(k);
        end
        build_tables();
        chk("sbox_00", 0, sbox[8'h00], 8'h63);
        chk("sbox_53", 0, sbox[8'h53], 8'hED);
        chk("sbox_01", 0, sbox[8'h01], 8'h7C);
        chk("isbox_63", 0, isbox[8'h63], 8'h00);

        // Reset held with random inputs
        repeat (6) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                st_valid[k] = 1'($urandom_range(0, 1)); ky_valid[k] = 1'($urandom_range(0, 1));
                st_dir[k] = 1'($urandom_range(0, 1));
                st_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
                ky_word[k] = $urandom();
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                chk("rst_ready", k, {st_ready[k], ky_ready[k]}, 0);
                chk("rst_sw_word", k, sw_word[k], 0);
            end
        end
        for (int k = 0; k < 2; k++) begin st_valid[k] = 1'b0; ky_valid[k] = 1'b0; end
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        for (int k = 0; k < 2; k++) chk("idle_busy", k, busy[k], 0);

        run_state(128'h00000000_00000053_00000000_00000000, 1'b0,
                  128'h63636363_636363ED_63636363_63636363);
        run_state({16{8'h63}}, 1'b1, 128'h0);

        // Key word
        for (int k = 0; k < 2; k++) begin ky_valid[k] = 1'b1; ky_word[k] = 32'h00000053; end
        #1;
        for (int k = 0; k < 2; k++) chk("t_ky_ready", k, ky_ready[k], 1);
        tick();
        for (int k = 0; k < 2; k++) begin
            ky_valid[k] = 1'b0;
            chk("t_ky_word", k, sw_word[k], 32'h00000053);
            chk("t_ky_dir", k, sw_dir[k], 0);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t_ky_done", k, ky_done[k], 1);
            chk("t_ky_result", k, ky_result[k], 32'h636363ED);
        end
        drain();

        // Contention from reset, both requesters continuously valid
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            st_valid[k] = 1'b1; ky_valid[k] = 1'b1; st_dir[k] = 1'b0;
            st_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()}; ky_word[k] = $urandom();
        end
        seq = '0; ngr = 0; nst1 = 0; prev_done = 1'b0; kdone_seen = 1'b0;
        repeat (30) begin
            tick();
            if (m_st_acc[1]) nst1++;
            if ((m_st_acc[0] || m_ky_acc[0]) && ngr < 4) begin
                seq = {seq[11:0], m_st_acc[0] ? 4'h1 : 4'h2};
                ngr++;
            end
            if (m_ky_acc[0] && !kdone_seen) begin
                kdone_seen = 1'b1;
                chk("rr_key_in_done_cycle", 0, prev_done, 1);
            end
            prev_done = st_done[0];
            for (int k = 0; k < 2; k++) begin
                if (m_st_acc[k]) st_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
                if (m_ky_acc[k]) ky_word[k] = $urandom();
            end
        end
        chk("rr_grant_seq", 0, seq, 16'h1212);
        chk("prio_starve", 1, nst1, 0);
        for (int k = 0; k < 2; k++) ky_valid[k] = 1'b0;
        waited = 0;
        while (!m_st_acc[1] && waited < 10) begin tick(); waited++; end
        chk("prio_state_served", 1, m_st_acc[1], 1);
        drain();

        // Reset in the middle of a state run
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int k = 0; k < 2; k++) begin st_valid[k] = 1'b1; st_dir[k] = 1'b0; st_data[k] = d; end
        tick();
        for (int k = 0; k < 2; k++) st_valid[k] = 1'b0;
        tick();
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("mr_busy", k, busy[k], 0);
            chk("mr_sw_word", k, sw_word[k], 0);
            chk("mr_st_result", k, st_result[k], 0);
        end
        repeat (3) begin
            tick();
            for (int k = 0; k < 2; k++) chk("mr_no_done", k, st_done[k], 0);
        end
        reset_n = 1'b1;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_state(d, 1'b0, subst_state(d, 1'b0));
        drain();

        // Random traffic with occasional resets
        for (int c = 0; c < 1500; c++) begin
            tick();
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0; tick(); tick(); reset_n = 1'b1;
            end
            for (int k = 0; k < 2; k++) begin
                if (!st_valid[k] || m_st_acc[k]) begin
                    st_valid[k] = ($urandom_range(0, 2) == 0);
                    st_dir[k] = 1'($urandom_range(0, 1));
                    st_data[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
                end
                if (!ky_valid[k] || m_ky_acc[k]) begin
                    ky_valid[k] = ($urandom_range(0, 3) == 0);
                    ky_word[k] = $urandom();
                end
            end
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
